// File: rtl/pcm_frame_packetizer.sv
// Buffers locked PCM frames in a two-slot ping-pong RAM and replays each one as
// HDR0,HDR1,SEQ,DATA... on a valid/ready byte stream. Define PCM_PKT_CHECKSUM_EN to append an XOR byte.
module pcm_frame_packetizer #(
  parameter int unsigned FRAME_SIZE = 128,
  parameter logic [7:0]  HDR0       = 8'hA5,
  parameter logic [7:0]  HDR1       = 8'h5A
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_lock,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic [7:0] drop_count,
  output logic [7:0] abort_count
);

  localparam logic [7:0] LAST_IDX  = 8'(FRAME_SIZE - 1);
  localparam logic [7:0] FRAME_LEN = 8'(FRAME_SIZE);

  typedef enum logic [2:0] {ST_IDLE, ST_HDR0, ST_HDR1, ST_SEQ, ST_DATA, ST_CSUM} state_t;

  logic [7:0] mem [0:511];
  logic [7:0] rd_data_reg;

  logic       wr_buf_reg;
  logic [7:0] wr_idx_reg;
  logic       frame_ok_reg;
  logic [7:0] seq_reg;
  logic [7:0] drop_count_reg;
  logic [7:0] abort_count_reg;
  logic [1:0] full_reg;
  logic [1:0] full_set;
  logic [1:0] full_clr;
  logic [7:0] seq_buf_reg [0:1];

  state_t     state_reg, state_next;
  logic       rd_buf_reg, rd_buf_next;
  logic [7:0] rd_ptr_reg, rd_ptr_next;
  logic [7:0] csum_reg, csum_next;
  logic [7:0] out_data_reg, out_data_next;
  logic       out_last_reg, out_last_next;
  logic       out_valid_reg;
  logic       buf_free;
  logic       pkt_end;

  // A frame may only write into its buffer if that buffer was free when byte 0 arrived.
  logic in_accept, frame_ok, frame_done, frame_store, out_accept;
  assign in_accept   = in_valid & in_lock;
  assign frame_ok    = (wr_idx_reg == 8'd0) ? ~full_reg[wr_buf_reg] : frame_ok_reg;
  assign frame_done  = in_accept && (wr_idx_reg == LAST_IDX);
  assign frame_store = frame_done & frame_ok;
  assign out_accept  = out_valid_reg & out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_buf
      assign full_set[gi] = frame_store & (wr_buf_reg == 1'(gi));
      assign full_clr[gi] = buf_free & (rd_buf_reg == 1'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (in_accept && frame_ok)
      mem[{wr_buf_reg, wr_idx_reg}] <= in_data;
    rd_data_reg <= mem[{rd_buf_next, rd_ptr_next}];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_buf_reg      <= 1'b0;
      wr_idx_reg      <= 8'd0;
      frame_ok_reg    <= 1'b0;
      seq_reg         <= 8'd0;
      drop_count_reg  <= 8'd0;
      abort_count_reg <= 8'd0;
      full_reg        <= 2'b00;
      for (int i = 0; i < 2; i++) seq_buf_reg[i] <= 8'd0;
    end else begin
      full_reg <= (full_reg & ~full_clr) | full_set;
      for (int i = 0; i < 2; i++)
        if (full_set[i]) seq_buf_reg[i] <= seq_reg;
      if (!in_lock) begin
        if (wr_idx_reg != 8'd0) begin
          wr_idx_reg <= 8'd0;
          if (abort_count_reg != 8'hFF) abort_count_reg <= abort_count_reg + 8'd1;
        end
      end else if (in_valid) begin
        if (frame_done) begin
          wr_idx_reg <= 8'd0;
          seq_reg    <= seq_reg + 8'd1;
          if (frame_ok) wr_buf_reg <= ~wr_buf_reg;
          else if (drop_count_reg != 8'hFF) drop_count_reg <= drop_count_reg + 8'd1;
        end else begin
          wr_idx_reg   <= wr_idx_reg + 8'd1;
          frame_ok_reg <= frame_ok;
        end
      end
    end
  end

  // rd_data_reg always holds the byte at rd_ptr, so DATA bytes stream without bubbles.
  always_comb begin
    state_next    = state_reg;
    rd_buf_next   = rd_buf_reg;
    rd_ptr_next   = rd_ptr_reg;
    csum_next     = csum_reg;
    out_data_next = out_data_reg;
    out_last_next = out_last_reg;
    buf_free      = 1'b0;
    pkt_end       = 1'b0;
    case (state_reg)
      ST_IDLE: if (full_reg[rd_buf_reg]) begin
        state_next    = ST_HDR0;
        out_data_next = HDR0;
        out_last_next = 1'b0;
        rd_ptr_next   = 8'd0;
      end
      ST_HDR0: if (out_accept) begin
        state_next    = ST_HDR1;
        out_data_next = HDR1;
      end
      ST_HDR1: if (out_accept) begin
        state_next    = ST_SEQ;
        out_data_next = seq_buf_reg[rd_buf_reg];
        csum_next     = seq_buf_reg[rd_buf_reg];
      end
      ST_SEQ: if (out_accept) begin
        state_next    = ST_DATA;
        out_data_next = rd_data_reg;
        csum_next     = csum_reg ^ rd_data_reg;
        rd_ptr_next   = 8'd1;
      end
      ST_DATA: if (out_accept) begin
        if (rd_ptr_reg == FRAME_LEN) begin
`ifdef PCM_PKT_CHECKSUM_EN
          state_next    = ST_CSUM;
          out_data_next = csum_reg;
          out_last_next = 1'b1;
`else
          pkt_end       = 1'b1;
`endif
        end else begin
          out_data_next = rd_data_reg;
          csum_next     = csum_reg ^ rd_data_reg;
          rd_ptr_next   = rd_ptr_reg + 8'd1;
`ifndef PCM_PKT_CHECKSUM_EN
          out_last_next = (rd_ptr_next == FRAME_LEN);
`endif
        end
      end
      ST_CSUM: if (out_accept) pkt_end = 1'b1;
      default: state_next = ST_IDLE;
    endcase
    if (pkt_end) begin
      buf_free      = 1'b1;
      rd_buf_next   = ~rd_buf_reg;
      out_last_next = 1'b0;
      rd_ptr_next   = 8'd0;
      if (full_reg[~rd_buf_reg]) begin
        state_next    = ST_HDR0;
        out_data_next = HDR0;
      end else begin
        state_next    = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      rd_buf_reg    <= 1'b0;
      rd_ptr_reg    <= 8'd0;
      csum_reg      <= 8'd0;
      out_data_reg  <= 8'd0;
      out_last_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rd_buf_reg    <= rd_buf_next;
      rd_ptr_reg    <= rd_ptr_next;
      csum_reg      <= csum_next;
      out_data_reg  <= out_data_next;
      out_last_reg  <= out_last_next;
      out_valid_reg <= (state_next != ST_IDLE);
    end
  end

  assign out_data    = out_data_reg;
  assign out_valid   = out_valid_reg;
  assign out_last    = out_last_reg;
  assign drop_count  = drop_count_reg;
  assign abort_count = abort_count_reg;

endmodule

// File: tb/tb_pcm_frame_packetizer.sv
// Self-checking bench for pcm_frame_packetizer: random frames vs a packet-level model.
module tb_pcm_frame_packetizer;
  localparam int FS = 128;
  localparam logic [7:0] H0 = 8'hA5;
  localparam logic [7:0] H1 = 8'h5A;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_lock = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic [7:0] drop_count;
  logic [7:0] abort_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pcm_frame_packetizer #(.FRAME_SIZE(FS), .HDR0(H0), .HDR1(H1)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid), .in_lock(in_lock),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .drop_count(drop_count), .abort_count(abort_count)
  );

  // Observer: records accepted bytes {last,data} and protocol violations.
  logic [8:0] cap_q[$];
  int pkt_done = 0, stall_viol = 0, bubble_viol = 0;
  logic p_valid = 1'b0, p_ready = 1'b0, p_last = 1'b0;
  logic [7:0] p_data = 8'd0;
  always @(negedge clk) begin
    if (!reset_n) begin
      p_valid = 1'b0;
      p_ready = 1'b0;
    end else begin
      if (p_valid && !p_ready && (!out_valid || out_data !== p_data || out_last !== p_last))
        stall_viol++;
      if (p_valid && p_ready && !p_last && !out_valid) bubble_viol++;
      if (out_valid && out_ready) begin
        cap_q.push_back({out_last, out_data});
        if (out_last) pkt_done++;
      end
      p_valid = out_valid; p_ready = out_ready; p_last = out_last; p_data = out_data;
    end
  end

  logic [7:0] cur_frame [0:255];
  logic [8:0] exp_q[$];
  logic [8:0] diff_got, diff_exp;
  bit rr_run = 1'b0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_lock = 1'b0; out_ready = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  function automatic void rand_frame();
    for (int i = 0; i < FS; i++) cur_frame[i] = 8'($urandom);
  endfunction

  // Expected packet for the current frame with sequence number seq.
  function automatic void push_expected(input logic [7:0] seq);
    logic [7:0] x;
    x = seq;
    exp_q.push_back({1'b0, H0});
    exp_q.push_back({1'b0, H1});
    exp_q.push_back({1'b0, seq});
    for (int i = 0; i < FS; i++) begin
      x = x ^ cur_frame[i];
`ifdef PCM_PKT_CHECKSUM_EN
      exp_q.push_back({1'b0, cur_frame[i]});
`else
      exp_q.push_back({(i == FS - 1), cur_frame[i]});
`endif
    end
`ifdef PCM_PKT_CHECKSUM_EN
    exp_q.push_back({1'b1, x});
`endif
  endfunction

  function automatic int first_diff(input int cb);
    diff_got = 9'd0; diff_exp = 9'd0;
    if (cap_q.size() - cb != exp_q.size()) return -2;
    for (int i = 0; i < exp_q.size(); i++)
      if (cap_q[cb + i] !== exp_q[i]) begin
        diff_got = cap_q[cb + i]; diff_exp = exp_q[i];
        return i;
      end
    return -1;
  endfunction

  task automatic send_frame(input int nbytes, input int max_gap);
    for (int i = 0; i < nbytes; i++) begin
      in_lock = 1'b1; in_valid = 1'b1; in_data = cur_frame[i];
      tick();
      in_valid = 1'b0;
      repeat ($urandom_range(max_gap, 0)) tick();
    end
  endtask

  task automatic wait_pkts(input int target, input int budget, output bit ok);
    int n;
    n = 0;
    while (pkt_done < target && n < budget) begin tick(); n++; end
    ok = (pkt_done >= target);
  endtask

  task automatic test_reset();
    do_reset();
    checks += 5;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    if (drop_count !== 8'd0) begin failures++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
    if (abort_count !== 8'd0) begin failures++; $display("FAIL reset_abort: got %0d want 0", abort_count); end
    $display("test_reset done");
  endtask

  task automatic test_basic_frame();
    int cb, pb, d; bit ok;
    do_reset();
    out_ready = 1'b1;
    exp_q.delete();
    for (int i = 0; i < FS; i++) cur_frame[i] = 8'(i);
    push_expected(8'd0);
    cb = cap_q.size(); pb = pkt_done;
    send_frame(FS, 0);
    tick();
    checks += 2;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_latency_valid: got %b want 1", out_valid); end
    if (out_data !== H0) begin failures++; $display("FAIL basic_latency_hdr0: got %h want %h", out_data, H0); end
    wait_pkts(pb + 1, 1000, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_timeout: got %0d packets want %0d", pkt_done - pb, 1); end
    d = first_diff(cb);
    checks++;
    if (d != -1) begin failures++; $display("FAIL basic_stream: diff_at=%0d got=%h want=%h got_len=%0d want_len=%0d", d, diff_got, diff_exp, cap_q.size() - cb, exp_q.size()); end
    checks++;
    if (drop_count !== 8'd0 || abort_count !== 8'd0) begin failures++; $display("FAIL basic_counters: got drop=%0d abort=%0d want 0,0", drop_count, abort_count); end
    $display("test_basic_frame done");
  endtask

  task automatic test_abort();
    int cb, pb, d; bit ok;
    do_reset();
    out_ready = 1'b1;
    rand_frame();
    send_frame(50, 2);
    in_lock = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (abort_count !== 8'd1) begin failures++; $display("FAIL abort_count: got %0d want 1", abort_count); end
    exp_q.delete();
    rand_frame();
    push_expected(8'd0);
    cb = cap_q.size(); pb = pkt_done;
    send_frame(FS, 1);
    wait_pkts(pb + 1, 1000, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL abort_timeout: got %0d packets want 1", pkt_done - pb); end
    d = first_diff(cb);
    checks++;
    if (d != -1) begin failures++; $display("FAIL abort_stream: diff_at=%0d got=%h want=%h got_len=%0d want_len=%0d", d, diff_got, diff_exp, cap_q.size() - cb, exp_q.size()); end
    checks++;
    if (abort_count !== 8'd1 || drop_count !== 8'd0) begin failures++; $display("FAIL abort_counters: got abort=%0d drop=%0d want 1,0", abort_count, drop_count); end
    $display("test_abort done");
  endtask

  task automatic test_backpressure_drop();
    int cb, pb, d; bit ok;
    do_reset();
    out_ready = 1'b0;
    exp_q.delete();
    cb = cap_q.size(); pb = pkt_done;
    rand_frame(); push_expected(8'd0); send_frame(FS, 0);
    rand_frame(); push_expected(8'd1); send_frame(FS, 0);
    rand_frame(); send_frame(FS, 0);
    repeat (3) tick();
    checks += 3;
    if (drop_count !== 8'd1) begin failures++; $display("FAIL bp_drop_count: got %0d want 1", drop_count); end
    if (cap_q.size() != cb) begin failures++; $display("FAIL bp_no_accept: got %0d bytes want 0", cap_q.size() - cb); end
    if (out_valid !== 1'b1 || out_data !== H0) begin failures++; $display("FAIL bp_stalled_hdr: got valid=%b data=%h want 1,%h", out_valid, out_data, H0); end
    out_ready = 1'b1;
    wait_pkts(pb + 2, 1000, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL bp_timeout: got %0d packets want 2", pkt_done - pb); end
    d = first_diff(cb);
    checks++;
    if (d != -1) begin failures++; $display("FAIL bp_stream: diff_at=%0d got=%h want=%h got_len=%0d want_len=%0d", d, diff_got, diff_exp, cap_q.size() - cb, exp_q.size()); end
    exp_q.delete();
    cb = cap_q.size(); pb = pkt_done;
    rand_frame(); push_expected(8'd3); send_frame(FS, 0);
    wait_pkts(pb + 1, 1000, ok);
    d = first_diff(cb);
    checks++;
    if (!ok || d != -1) begin failures++; $display("FAIL bp_seq_gap: diff_at=%0d got=%h want=%h got_len=%0d want_len=%0d", d, diff_got, diff_exp, cap_q.size() - cb, exp_q.size()); end
    $display("test_backpressure_drop done");
  endtask

  task automatic test_random_ready();
    int cb, pb, sv, bv, d, n; bit ok;
    do_reset();
    exp_q.delete();
    cb = cap_q.size(); pb = pkt_done; sv = stall_viol; bv = bubble_viol;
    rr_run = 1'b1;
    fork
      begin
        while (rr_run) begin
          out_ready = 1'($urandom_range(1, 0));
          tick();
        end
      end
    join_none
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while ((k - (pkt_done - pb)) >= 2 && n < 3000) begin tick(); n++; end
      repeat (3) tick();
      rand_frame();
      push_expected(8'(k));
      send_frame(FS, $urandom_range(2, 0));
    end
    wait_pkts(pb + 6, 4000, ok);
    rr_run = 1'b0;
    tick(); tick();
    out_ready = 1'b1;
    checks++;
    if (!ok) begin failures++; $display("FAIL rand_timeout: got %0d packets want 6", pkt_done - pb); end
    d = first_diff(cb);
    checks++;
    if (d != -1) begin failures++; $display("FAIL rand_stream: diff_at=%0d got=%h want=%h got_len=%0d want_len=%0d", d, diff_got, diff_exp, cap_q.size() - cb, exp_q.size()); end
    checks += 3;
    if (stall_viol != sv) begin failures++; $display("FAIL rand_stall_hold: got %0d violations want 0", stall_viol - sv); end
    if (bubble_viol != bv) begin failures++; $display("FAIL rand_bubble: got %0d bubbles want 0", bubble_viol - bv); end
    if (drop_count !== 8'd0) begin failures++; $display("FAIL rand_drop: got %0d want 0", drop_count); end
    $display("test_random_ready done");
  endtask

  task automatic test_reset_mid_packet();
    int cb, pb, d, n; bit ok;
    do_reset();
    out_ready = 1'b1;
    rand_frame(); send_frame(10, 0);
    in_lock = 1'b0; tick();
    checks++;
    if (abort_count !== 8'd1) begin failures++; $display("FAIL rst_pre_abort: got %0d want 1", abort_count); end
    cb = cap_q.size();
    rand_frame(); send_frame(FS, 0);
    n = 0;
    while (cap_q.size() - cb < 23 && n < 500) begin tick(); n++; end
    checks++;
    if (cap_q.size() - cb < 23) begin failures++; $display("FAIL rst_reach_byte20: got %0d bytes want 23", cap_q.size() - cb); end
    reset_n = 1'b0; in_lock = 1'b0;
    tick();
    checks += 3;
    if (out_valid !== 1'b0 || out_last !== 1'b0) begin failures++; $display("FAIL rst_mid_valid: got valid=%b last=%b want 0,0", out_valid, out_last); end
    if (abort_count !== 8'd0 || drop_count !== 8'd0) begin failures++; $display("FAIL rst_mid_counters: got abort=%0d drop=%0d want 0,0", abort_count, drop_count); end
    if (out_data !== 8'h00) begin failures++; $display("FAIL rst_mid_data: got %h want 00", out_data); end
    reset_n = 1'b1;
    tick();
    exp_q.delete();
    cb = cap_q.size(); pb = pkt_done;
    rand_frame(); push_expected(8'd0); send_frame(FS, 1);
    wait_pkts(pb + 1, 1000, ok);
    d = first_diff(cb);
    checks++;
    if (!ok || d != -1) begin failures++; $display("FAIL rst_next_seq0: diff_at=%0d got=%h want=%h got_len=%0d want_len=%0d", d, diff_got, diff_exp, cap_q.size() - cb, exp_q.size()); end
    $display("test_reset_mid_packet done");
  endtask

  task automatic test_lock_fall_last();
    int cb, pb, d; bit ok;
    do_reset();
    out_ready = 1'b1;
    cb = cap_q.size();
    rand_frame();
    send_frame(FS - 1, 0);
    in_data = cur_frame[FS - 1]; in_valid = 1'b1; in_lock = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (FS + 10) tick();
    checks += 2;
    if (abort_count !== 8'd1) begin failures++; $display("FAIL lastbyte_abort: got %0d want 1", abort_count); end
    if (cap_q.size() != cb || out_valid !== 1'b0) begin failures++; $display("FAIL lastbyte_no_pkt: got %0d bytes valid=%b want 0,0", cap_q.size() - cb, out_valid); end
    exp_q.delete();
    cb = cap_q.size(); pb = pkt_done;
    rand_frame(); push_expected(8'd0); send_frame(FS, 0);
    wait_pkts(pb + 1, 1000, ok);
    d = first_diff(cb);
    checks++;
    if (!ok || d != -1) begin failures++; $display("FAIL lastbyte_next_seq0: diff_at=%0d got=%h want=%h got_len=%0d want_len=%0d", d, diff_got, diff_exp, cap_q.size() - cb, exp_q.size()); end
    $display("test_lock_fall_last done");
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_abort();
    test_backpressure_drop();
    test_random_ready();
    test_reset_mid_packet();
    test_lock_fall_last();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
